// File: rtl/lfsr_rr_server.sv
// Round-robin server handing fresh 8-bit Fibonacci LFSR words (taps 7,5,4,3) to N requesters.
// Define LFSR_RR_SERVER_SEED_EN to add the SEED_VALID/SEED/SEED_READY seed-load path.
module lfsr_rr_server #(
    parameter int unsigned N     = 4,
    parameter int unsigned STEPS = 8,
    parameter logic [7:0]  INIT  = 8'h01
) (
    input  logic         CLK,
    input  logic         ASYNCRESET,
    input  logic [N-1:0] REQ,
    output logic [N-1:0] GNT,
    output logic         VALID,
    output logic [7:0]   DATA,
    input  logic         ACK,
    output logic         BUSY
`ifdef LFSR_RR_SERVER_SEED_EN
    ,
    input  logic         SEED_VALID,
    input  logic [7:0]   SEED,
    output logic         SEED_READY
`endif
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_DELIVER
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       lfsr_q,  lfsr_d;
    logic [3:0]       cnt_q,   cnt_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;
    logic [IDX_W-1:0] gidx_q,  gidx_d;
    logic [N-1:0]     gnt_q,   gnt_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_q,  data_d;

    logic [7:0]       lfsr_next;
    logic             rr_found;
    logic [IDX_W-1:0] rr_pick;
    logic [IDX_W-1:0] rr_cand;
    logic [IDX_W-1:0] ptr_inc;
    logic             seed_load;
    logic [7:0]       seed_value;

`ifdef LFSR_RR_SERVER_SEED_EN
    // A zero seed would lock the LFSR at zero forever, so INIT stands in for it.
    assign seed_load  = SEED_VALID;
    assign seed_value = (SEED == 8'h00) ? INIT : SEED;
    assign SEED_READY = (state_q == S_IDLE);
`else
    assign seed_load  = 1'b0;
    assign seed_value = INIT;
`endif

    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign ptr_inc   = (gidx_q == IDX_W'(N - 1)) ? '0 : gidx_q + 1'b1;

    // First set request at or after the pointer, wrapping modulo N.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_cand  = '0;
        for (int i = 0; i < int'(N); i++) begin
            rr_cand = IDX_W'((int'(ptr_q) + i) % int'(N));
            if (!rr_found && REQ[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    // NOTE: every variable gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        data_d  = data_q;

        unique case (state_q)
            S_IDLE: begin
                if (seed_load) begin
                    lfsr_d = seed_value;
                end else if (rr_found) begin
                    gnt_d   = N'(1) << rr_pick;
                    gidx_d  = rr_pick;
                    cnt_d   = '0;
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                lfsr_d = lfsr_next;
                cnt_d  = cnt_q + 4'd1;
                // The last shift and the word capture share one edge, giving a STEPS+2 cycle period.
                if (cnt_q == 4'(STEPS - 1)) begin
                    data_d  = lfsr_next;
                    valid_d = 1'b1;
                    state_d = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (ACK) begin
                    valid_d = 1'b0;
                    gnt_d   = '0;
                    ptr_d   = ptr_inc;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the pre-edge values.
    // NOTE: every flop is reset, including DATA, so outputs drop to zero without waiting for CLK.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q <= S_IDLE;
            lfsr_q  <= INIT;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gidx_q  <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign GNT   = gnt_q;
    assign VALID = valid_q;
    assign DATA  = data_q;
    assign BUSY  = (state_q != S_IDLE);

endmodule

// File: tb/tb_lfsr_rr_server.sv
// Directed self-checking bench for lfsr_rr_server (N=4, STEPS=8, INIT=8'h01).
// Seed-path vectors are compiled in only when LFSR_RR_SERVER_SEED_EN is defined.
module tb_lfsr_rr_server;

    logic       CLK = 1'b0;
    logic       ASYNCRESET;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic       VALID;
    logic [7:0] DATA;
    logic       ACK;
    logic       BUSY;
`ifdef LFSR_RR_SERVER_SEED_EN
    logic       SEED_VALID;
    logic [7:0] SEED;
    logic       SEED_READY;
`endif

    int checks   = 0;
    int failures = 0;

    lfsr_rr_server #(.N(4), .STEPS(8), .INIT(8'h01)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .REQ        (REQ),
        .GNT        (GNT),
        .VALID      (VALID),
        .DATA       (DATA),
        .ACK        (ACK),
        .BUSY       (BUSY)
`ifdef LFSR_RR_SERVER_SEED_EN
        ,
        .SEED_VALID (SEED_VALID),
        .SEED       (SEED),
        .SEED_READY (SEED_READY)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Eight Fibonacci shifts of the reference LFSR: one delivered word.
    function automatic logic [7:0] lfsr_word(input logic [7:0] s);
        logic [7:0] v;
        v = s;
        for (int k = 0; k < 8; k++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!VALID && edges < 40);
        check("valid_seen", 32'(VALID), 32'd1);
    endtask

    task automatic pulse_reset();
        ASYNCRESET = 1'b1;
        #3;
        ASYNCRESET = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         bad;
        logic [7:0] exp_lfsr;
        logic [3:0] rr_gnt [5];

        rr_gnt[0] = 4'b0001; rr_gnt[1] = 4'b0010; rr_gnt[2] = 4'b0100;
        rr_gnt[3] = 4'b1000; rr_gnt[4] = 4'b0001;

        ASYNCRESET = 1'b1;
        REQ = '0;
        ACK = 1'b0;
`ifdef LFSR_RR_SERVER_SEED_EN
        SEED_VALID = 1'b0;
        SEED = 8'h00;
`endif
        #22;
        check("rst_gnt",   32'(GNT),   32'h0);
        check("rst_valid", 32'(VALID), 32'h0);
        check("rst_data",  32'(DATA),  32'h0);
        check("rst_busy",  32'(BUSY),  32'h0);
        tick();
        ASYNCRESET = 1'b0;
        exp_lfsr = 8'h01;

        // Single requester, ACK tied high: 1C then 4B, ten cycles apart.
        REQ = 4'b0001;
        ACK = 1'b1;
        tick();
        check("first_gnt",  32'(GNT),  32'h1);
        check("first_busy", 32'(BUSY), 32'h1);
        lat = 1;
        begin
            int more;
            wait_valid(more);
            lat += more;
        end
        check("first_lat",  32'(lat),  32'd9);
        check("first_data", 32'(DATA), 32'h1C);
        wait_valid(lat);
        check("second_lat",  32'(lat),  32'd10);
        check("second_data", 32'(DATA), 32'h4B);
        check("second_gnt",  32'(GNT),  32'h1);
        REQ = '0;
        tick();
        check("ack_valid", 32'(VALID), 32'h0);
        check("ack_gnt",   32'(GNT),   32'h0);
        check("ack_busy",  32'(BUSY),  32'h0);

        // Round robin from a fresh pointer: grants 0,1,2,3,0.
        pulse_reset();
        exp_lfsr = 8'h01;
        REQ = 4'b1111;
        for (int w = 0; w < 5; w++) begin
            wait_valid(lat);
            exp_lfsr = lfsr_word(exp_lfsr);
            check("rr_lat",  32'(lat),  (w == 0) ? 32'd9 : 32'd10);
            check("rr_gnt",  32'(GNT),  32'(rr_gnt[w]));
            check("rr_data", 32'(DATA), 32'(exp_lfsr));
        end
        REQ = '0;
        tick();

        // Backpressure: word held 20 cycles, LFSR frozen meanwhile.
        ACK = 1'b0;
        REQ = 4'b0010;
        wait_valid(lat);
        exp_lfsr = lfsr_word(exp_lfsr);
        check("bp_lat",  32'(lat),  32'd9);
        check("bp_gnt",  32'(GNT),  32'h2);
        check("bp_data", 32'(DATA), 32'(exp_lfsr));
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (VALID !== 1'b1 || GNT !== 4'b0010 || DATA !== exp_lfsr) bad++;
        end
        check("bp_stable", 32'(bad), 32'd0);
        REQ = '0;
        ACK = 1'b1;
        tick();
        check("bp_ack_valid", 32'(VALID), 32'h0);
        check("bp_ack_gnt",   32'(GNT),   32'h0);

        // Requester 2 withdraws mid-STEP; the word still goes to it and the pointer moves to 3.
        REQ = 4'b0100;
        tick();
        check("wd_gnt", 32'(GNT), 32'h4);
        REQ = '0;
        wait_valid(lat);
        exp_lfsr = lfsr_word(exp_lfsr);
        check("wd_dgnt", 32'(GNT),  32'h4);
        check("wd_data", 32'(DATA), 32'(exp_lfsr));
        tick();
        REQ = 4'b1111;
        tick();
        check("wd_next_gnt", 32'(GNT), 32'h8);
        REQ = '0;
        wait_valid(lat);
        exp_lfsr = lfsr_word(exp_lfsr);
        check("wd_next_data", 32'(DATA), 32'(exp_lfsr));
        tick();

        // Reset during the fourth STEP cycle clears outputs before the next edge.
        REQ = 4'b0001;
        tick();
        tick();
        tick();
        tick();
        #2;
        ASYNCRESET = 1'b1;
        #1;
        check("mid_rst_gnt",   32'(GNT),   32'h0);
        check("mid_rst_valid", 32'(VALID), 32'h0);
        check("mid_rst_busy",  32'(BUSY),  32'h0);
        check("mid_rst_data",  32'(DATA),  32'h0);
        #1;
        ASYNCRESET = 1'b0;
        wait_valid(lat);
        check("post_rst_lat",  32'(lat),  32'd9);
        check("post_rst_data", 32'(DATA), 32'h1C);
        exp_lfsr = 8'h1C;
        REQ = '0;
        tick();

`ifdef LFSR_RR_SERVER_SEED_EN
        // Zero seed beats a same-cycle request and reloads INIT.
        check("seed_ready_idle", 32'(SEED_READY), 32'h1);
        SEED_VALID = 1'b1;
        SEED = 8'h00;
        REQ = 4'b0010;
        tick();
        check("seed_wins_gnt",  32'(GNT),  32'h0);
        check("seed_wins_busy", 32'(BUSY), 32'h0);
        SEED_VALID = 1'b0;
        wait_valid(lat);
        check("seed0_lat",  32'(lat),  32'd9);
        check("seed0_data", 32'(DATA), 32'h1C);
        REQ = '0;
        tick();

        // Seed during STEP is ignored.
        REQ = 4'b0100;
        tick();
        SEED_VALID = 1'b1;
        SEED = 8'hA5;
        check("seed_ready_step", 32'(SEED_READY), 32'h0);
        tick();
        tick();
        SEED_VALID = 1'b0;
        REQ = '0;
        wait_valid(lat);
        check("seed_step_data", 32'(DATA), 32'h4B);
        tick();

        // Non-zero seed loaded in IDLE sets the next word.
        SEED_VALID = 1'b1;
        SEED = 8'hA5;
        tick();
        SEED_VALID = 1'b0;
        REQ = 4'b1000;
        wait_valid(lat);
        check("seed_a5_gnt",  32'(GNT),  32'h8);
        check("seed_a5_data", 32'(DATA), 32'(lfsr_word(8'hA5)));
        REQ = '0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
